// File: rtl/sif_fp16_pkg.sv
// rtl/sif_fp16_pkg.sv - shared fp16 widths, constants and feeder state encoding
package sif_fp16_pkg;

   localparam int FP16_W = 16;

   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
   localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
   localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;

   typedef enum logic [1:0] {
      LOAD,
      WAIT_DEN,
      ISSUE
   } state_t;

endpackage

// File: rtl/sif_vec_buf.sv
// rtl/sif_vec_buf.sv - numerator buffer, one synchronous write port, one asynchronous read port
module sif_vec_buf
   import sif_fp16_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [FP16_W-1:0] wdat,
   input  logic [AW-1:0]     raddr,
   output logic [FP16_W-1:0] rdat
);

   // No reset: contents are only ever read back after being written in LOAD.
   logic [FP16_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdat;
      end
   end

   assign rdat = mem[raddr];

endmodule

// File: rtl/sif_softmax_div_feeder.sv
// rtl/sif_softmax_div_feeder.sv - buffers one vector of exp(x) and feeds {numerator, sum} pairs to the divider
module sif_softmax_div_feeder
   import sif_fp16_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              X_vld,
   input  logic [FP16_W-1:0] X_dat,
   input  logic              X_last,
   output logic              X_rdy,
   input  logic              D_vld,
   input  logic [FP16_W-1:0] D_dat,
   output logic              D_rdy,
   output logic              A_vld,
   output logic [FP16_W-1:0] A_dat,
   input  logic              A_rdy,
   output logic              B_vld,
   output logic [FP16_W-1:0] B_dat,
   input  logic              B_rdy,
   output logic              busy
);

   state_t            state;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       len;
   logic [FP16_W-1:0] den;
   logic              a_done;
   logic              b_done;

   logic x_hs, d_hs, a_hs, b_hs;
   logic x_end, pair_done, last_pair;

   assign X_rdy = ~rst & (state == LOAD);
   assign D_rdy = ~rst & (state == WAIT_DEN);
   assign A_vld = ~rst & (state == ISSUE) & ~a_done;
   assign B_vld = ~rst & (state == ISSUE) & ~b_done;
   assign busy  = ~rst & ((state != LOAD) | (wr_ptr != '0));
   assign B_dat = den;

   assign x_hs = X_vld & X_rdy;
   assign d_hs = D_vld & D_rdy;
   assign a_hs = A_vld & A_rdy;
   assign b_hs = B_vld & B_rdy;

   // The DEPTH-th element closes the vector even without X_last.
   assign x_end     = X_last | (wr_ptr == AW'(DEPTH - 1));
   // A and B may be accepted in different cycles; a pair is done once both have gone.
   assign pair_done = (a_done | a_hs) & (b_done | b_hs);
   assign last_pair = ({1'b0, rd_ptr} == (len - (AW+1)'(1)));

   sif_vec_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (x_hs),
      .waddr (wr_ptr),
      .wdat  (X_dat),
      .raddr (rd_ptr),
      .rdat  (A_dat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= LOAD;
         wr_ptr <= '0;
         rd_ptr <= '0;
         len    <= '0;
         den    <= FP16_ZERO;
         a_done <= 1'b0;
         b_done <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (x_hs) begin
                  if (x_end) begin
                     len    <= {1'b0, wr_ptr} + (AW+1)'(1);
                     wr_ptr <= '0;
                     state  <= WAIT_DEN;
                  end else begin
                     wr_ptr <= wr_ptr + AW'(1);
                  end
               end
            end
            WAIT_DEN: begin
               if (d_hs) begin
                  den    <= D_dat;
                  rd_ptr <= '0;
                  a_done <= 1'b0;
                  b_done <= 1'b0;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (pair_done) begin
                  a_done <= 1'b0;
                  b_done <= 1'b0;
                  rd_ptr <= rd_ptr + AW'(1);
                  if (last_pair) begin
                     state <= LOAD;
                  end
               end else begin
                  a_done <= a_done | a_hs;
                  b_done <= b_done | b_hs;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule
